// File: rtl/panel_pkg.sv
// Shared constants for the iCEBreaker panel front end: reset-sequencer state
// encoding and the board-build default timing parameters.
package panel_pkg;

   localparam int DIVIDER_DEF       = 500;
   localparam int DELAY_BIT_DEF     = 15;
   localparam int DEBOUNCE_BITS_DEF = 16;
   localparam int ROWMAX_W_DEF      = 4;

   localparam logic [1:0] ST_HOLD  = 2'd0;
   localparam logic [1:0] ST_ALIGN = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser plus candidate/stable-count debouncer for a static
// strap bus; stable_ok means cand has held for 2^BITS-1 consecutive cycles.
module sync_debounce #(
   parameter int W    = 4,
   parameter int BITS = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] raw,
   output logic [W-1:0] cand,
   output logic         stable_ok
);

   localparam logic [BITS-1:0] STABLE_ONE = BITS'(1);

   logic [W-1:0]    meta_q, meta_d;
   logic [W-1:0]    sync_q, sync_d;
   logic [W-1:0]    cand_q, cand_d;
   logic [BITS-1:0] stable_q, stable_d;

   always_comb begin
      meta_d   = raw;
      sync_d   = meta_q;
      cand_d   = cand_q;
      stable_d = stable_q;
      if (sync_q != cand_q) begin
         cand_d   = sync_q;
         stable_d = '0;
      end else if (!(&stable_q)) begin
         stable_d = stable_q + STABLE_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta_q   <= '0;
         sync_q   <= '0;
         cand_q   <= '0;
         stable_q <= '0;
      end else begin
         meta_q   <= meta_d;
         sync_q   <= sync_d;
         cand_q   <= cand_d;
         stable_q <= stable_d;
      end
   end

   assign cand      = cand_q;
   assign stable_ok = &stable_q;

endmodule

// File: rtl/panel_clk_rst_gen.sv
// Panel core front end: divides clk into clk_dut, sequences panel_reset so it
// releases on a clk_dut falling edge, and debounces the rowmax strap.
module panel_clk_rst_gen
   import panel_pkg::*;
#(
   parameter int DIVIDER       = DIVIDER_DEF,
   parameter int DELAY_BIT     = DELAY_BIT_DEF,
   parameter int DEBOUNCE_BITS = DEBOUNCE_BITS_DEF,
   parameter int ROWMAX_W      = ROWMAX_W_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ROWMAX_W-1:0] rowmax_raw,
   output logic                clk_dut,
   output logic                clk_dut_rise,
   output logic                panel_reset,
   output logic [ROWMAX_W-1:0] rowmax,
   output logic                rowmax_changed
);

   localparam int CNT_W = (DIVIDER > 0) ? $clog2(DIVIDER + 1) : 1;
   localparam int DLY_W = DELAY_BIT + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVIDER);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [DLY_W-1:0] DLY_ONE = DLY_W'(1);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                clk_dut_q, clk_dut_d;
   logic                rise_q, rise_d;
   logic [DLY_W-1:0]    delay_q, delay_d;
   logic [1:0]          state_q, state_d;
   logic                panel_reset_q, panel_reset_d;
   logic [ROWMAX_W-1:0] rowmax_q, rowmax_d;
   logic                changed_q, changed_d;
   logic                fall_tick;
   logic [ROWMAX_W-1:0] cand;
   logic                stable_ok;

   sync_debounce #(
      .W    (ROWMAX_W),
      .BITS (DEBOUNCE_BITS)
   ) u_rowmax_db (
      .clk       (clk),
      .reset_n   (reset_n),
      .raw       (rowmax_raw),
      .cand      (cand),
      .stable_ok (stable_ok)
   );

   always_comb begin
      cnt_d     = cnt_q + CNT_ONE;
      clk_dut_d = clk_dut_q;
      rise_d    = 1'b0;
      fall_tick = 1'b0;
      if (cnt_q == CNT_MAX) begin
         cnt_d     = '0;
         clk_dut_d = !clk_dut_q;
         rise_d    = !clk_dut_q;
         fall_tick = clk_dut_q;
      end

      delay_d       = delay_q;
      state_d       = state_q;
      panel_reset_d = panel_reset_q;
      case (state_q)
         ST_HOLD: begin
            if (delay_q[DELAY_BIT]) state_d = ST_ALIGN;
            else                    delay_d = delay_q + DLY_ONE;
         end
         // Releasing on the falling edge gives the core a full low half-period
         // before its first rising edge.
         ST_ALIGN: begin
            if (fall_tick) begin
               state_d       = ST_RUN;
               panel_reset_d = 1'b0;
            end
         end
         ST_RUN: panel_reset_d = 1'b0;
         default: begin
            state_d       = ST_HOLD;
            panel_reset_d = 1'b1;
         end
      endcase

      // Strap updates only land on clk_dut falling edges so the core never
      // samples rowmax mid-change.
      rowmax_d  = rowmax_q;
      changed_d = 1'b0;
      if (stable_ok && (cand != rowmax_q) && fall_tick) begin
         rowmax_d  = cand;
         changed_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q         <= '0;
         clk_dut_q     <= 1'b0;
         rise_q        <= 1'b0;
         delay_q       <= '0;
         state_q       <= ST_HOLD;
         panel_reset_q <= 1'b1;
         rowmax_q      <= '0;
         changed_q     <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         clk_dut_q     <= clk_dut_d;
         rise_q        <= rise_d;
         delay_q       <= delay_d;
         state_q       <= state_d;
         panel_reset_q <= panel_reset_d;
         rowmax_q      <= rowmax_d;
         changed_q     <= changed_d;
      end
   end

   assign clk_dut        = clk_dut_q;
   assign clk_dut_rise   = rise_q;
   assign panel_reset    = panel_reset_q;
   assign rowmax         = rowmax_q;
   assign rowmax_changed = changed_q;

endmodule
